// File: rtl/ahb_slave.sv
// AHB-Lite responder that turns each accepted bus transfer into one valid/ready
// request on a simple target interface, stretching the data phase until the target completes.
module ahb_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk_ahb,
    input  logic                  i_rst_ahb,
    input  logic                  i_hsel,
    input  logic                  i_hready,
    input  logic [1:0]            i_htrans,
    input  logic                  i_hwrite,
    input  logic [2:0]            i_hsize,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    output logic                  o_hreadyout,
    output logic                  o_hresp,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_valid,
    output logic                  o_rd0_wr1,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [2:0]            o_size,
    input  logic                  i_ready,
    input  logic                  i_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_WR_REQ,
        S_RD_REQ,
        S_RD_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  accept;

    // Only NONSEQ/SEQ matter; BUSY and IDLE are both treated as no transfer.
    logic unused_htrans;
    assign unused_htrans = i_htrans[0];

    assign accept = ((state_q == S_IDLE) || (state_q == S_ERR2)) &&
                    i_hsel && i_hready && i_htrans[1];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    addr_d  = i_haddr;
                    write_d = i_hwrite;
                    size_d  = i_hsize;
                    if (i_hsize > 3'b010) begin
                        state_d = S_ERR1;
                    end else if (i_hwrite) begin
                        state_d = S_WR_DATA;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_WR_DATA: begin
                wdata_d = i_hwdata;
                state_d = S_WR_REQ;
            end
            S_WR_REQ: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (i_ready) begin
                    if (i_rd_valid) begin
                        rdata_d = i_rd_data;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (i_rd_valid) begin
                    rdata_d = i_rd_data;
                    state_d = S_IDLE;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
        if (i_rst_ahb) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'b000;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Every cycle of the data phase except the completing one holds the bus.
    assign o_hreadyout = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign o_hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign o_valid     = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
    assign o_hrdata    = rdata_q;
    assign o_rd0_wr1   = write_q;
    assign o_addr      = addr_q;
    assign o_wr_data   = wdata_q;
    assign o_size      = size_q;

endmodule

// File: tb/tb_ahb_slave.sv
// Scoreboard bench for ahb_slave: stimulus pushes expected target requests and bus
// responses into queues; monitors pop and compare when the DUT presents them.
module tb_ahb_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_hsel = 1'b0;
    logic [1:0]  i_htrans = 2'b00;
    logic        i_hwrite = 1'b0;
    logic [2:0]  i_hsize = 3'b000;
    logic [31:0] i_haddr = '0;
    logic [31:0] i_hwdata = '0;
    logic        i_ready = 1'b0;
    logic        i_rd_valid = 1'b0;
    logic [31:0] i_rd_data = '0;
    logic        hreadyBus;
    logic        o_hreadyout, o_hresp, o_valid, o_rd0_wr1;
    logic [31:0] o_hrdata, o_addr, o_wr_data;
    logic [2:0]  o_size;

    always #5 clk = ~clk;

    // Single-slave bus: HREADY is this slave's own HREADYOUT.
    assign hreadyBus = o_hreadyout;

    ahb_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_clk_ahb(clk), .i_rst_ahb(rst), .i_hsel(i_hsel), .i_hready(hreadyBus),
        .i_htrans(i_htrans), .i_hwrite(i_hwrite), .i_hsize(i_hsize), .i_haddr(i_haddr),
        .i_hwdata(i_hwdata), .o_hreadyout(o_hreadyout), .o_hresp(o_hresp),
        .o_hrdata(o_hrdata), .o_valid(o_valid), .o_rd0_wr1(o_rd0_wr1), .o_addr(o_addr),
        .o_wr_data(o_wr_data), .o_size(o_size), .i_ready(i_ready),
        .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [2:0]  size;
    } req_t;

    typedef struct packed {
        logic        resp;
        logic [31:0] rdata;
        logic [31:0] waits;
    } rsp_t;

    req_t        reqQ[$];
    rsp_t        rspQ[$];
    int          checks = 0;
    int          errors = 0;
    int          readyDelay = 0;
    int          rdDelay = 0;
    logic [31:0] rdData = '0;
    logic [31:0] lastRead = '0;
    logic        dataPhase = 1'b0;
    logic        prevHs = 1'b0;
    int          waitCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_hreadyout"}, 32'(o_hreadyout), 32'd1);
        checkOutput({tag, "_hresp"}, 32'(o_hresp), 32'd0);
        checkOutput({tag, "_hrdata"}, o_hrdata, 32'd0);
        checkOutput({tag, "_valid"}, 32'(o_valid), 32'd0);
        checkOutput({tag, "_rd0_wr1"}, 32'(o_rd0_wr1), 32'd0);
        checkOutput({tag, "_addr"}, o_addr, 32'd0);
        checkOutput({tag, "_wr_data"}, o_wr_data, 32'd0);
        checkOutput({tag, "_size"}, 32'(o_size), 32'd0);
    endtask

    // Issues one NONSEQ transfer from a negedge, queues its expected outcome, and
    // returns at the negedge after the address phase has been accepted.
    task automatic applyStimulus(input logic wr, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_t q;
        rsp_t r;
        int   n;
        if (size > 3'b010) begin
            r = '{resp: 1'b1, rdata: lastRead, waits: 32'd1};
        end else if (wr) begin
            q = '{addr: addr, wr: 1'b1, data: wdata, size: size};
            reqQ.push_back(q);
            r = '{resp: 1'b0, rdata: lastRead, waits: 32'(2 + readyDelay)};
        end else begin
            q = '{addr: addr, wr: 1'b0, data: 32'd0, size: size};
            reqQ.push_back(q);
            lastRead = rdData;
            r = '{resp: 1'b0, rdata: rdData, waits: 32'(1 + readyDelay + rdDelay)};
        end
        rspQ.push_back(r);
        i_hsel   = 1'b1;
        i_htrans = 2'b10;
        i_hwrite = wr;
        i_hsize  = size;
        i_haddr  = addr;
        n = 0;
        while (o_hreadyout !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) reportFail("address_phase_timeout");
        @(negedge clk);
        i_hwdata = wdata;
        i_hsel   = 1'b0;
        i_htrans = 2'b00;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((reqQ.size() != 0 || rspQ.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) reportFail({name, "_drain_timeout"});
        @(negedge clk);
    endtask

    // Target model: accepts after readyDelay cycles of o_valid, returns read data
    // rdDelay cycles after the accept (0 means in the accept cycle).
    initial begin : targetModel
        int  waitCnt;
        int  rdCnt;
        logic rdPending;
        waitCnt = 0;
        rdCnt = 0;
        rdPending = 1'b0;
        forever begin
            @(negedge clk);
            i_ready = 1'b0;
            i_rd_valid = 1'b0;
            if (rst) begin
                waitCnt = 0;
                rdCnt = 0;
                rdPending = 1'b0;
            end else if (rdPending) begin
                if (rdCnt == rdDelay) begin
                    i_rd_valid = 1'b1;
                    i_rd_data = rdData;
                    rdPending = 1'b0;
                end else begin
                    rdCnt++;
                end
            end else if (o_valid) begin
                if (waitCnt == readyDelay) begin
                    i_ready = 1'b1;
                    waitCnt = 0;
                    if (!o_rd0_wr1) begin
                        if (rdDelay == 0) begin
                            i_rd_valid = 1'b1;
                            i_rd_data = rdData;
                        end else begin
                            rdPending = 1'b1;
                            rdCnt = 1;
                        end
                    end
                end else begin
                    waitCnt++;
                end
            end
        end
    end

    // Monitor: bus responses at data-phase completion, target requests while valid.
    initial begin : monitor
        rsp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                dataPhase = 1'b0;
                prevHs = 1'b0;
                waitCount = 0;
            end else begin
                if (dataPhase) begin
                    if (!o_hreadyout) begin
                        waitCount++;
                        if (rspQ.size() != 0) checkOutput("hresp_wait", 32'(o_hresp), 32'(rspQ[0].resp));
                    end else if (rspQ.size() == 0) begin
                        reportFail("unexpected_bus_completion");
                    end else begin
                        r = rspQ.pop_front();
                        checkOutput("hresp", 32'(o_hresp), 32'(r.resp));
                        checkOutput("hrdata", o_hrdata, r.rdata);
                        checkOutput("wait_states", 32'(waitCount), r.waits);
                    end
                end
                if (o_hreadyout) begin
                    dataPhase = i_hsel && i_htrans[1];
                    waitCount = 0;
                end
                if (prevHs) checkOutput("valid_drop", 32'(o_valid), 32'd0);
                prevHs = o_valid && i_ready;
                if (o_valid) begin
                    if (reqQ.size() == 0) begin
                        reportFail("unexpected_request");
                    end else begin
                        checkOutput("req_addr", o_addr, reqQ[0].addr);
                        checkOutput("req_rd0_wr1", 32'(o_rd0_wr1), 32'(reqQ[0].wr));
                        checkOutput("req_size", 32'(o_size), 32'(reqQ[0].size));
                        if (reqQ[0].wr) checkOutput("req_wr_data", o_wr_data, reqQ[0].data);
                        if (i_ready) void'(reqQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [1:0] idleTrans [4];
        logic       idleSel   [4];
        idleTrans = '{2'b01, 2'b00, 2'b10, 2'b11};
        idleSel   = '{1'b1, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
        waitDrain("write_word");

        rdData = 32'h1234_5678;
        applyStimulus(1'b0, 3'b010, 32'h0000_0020, 32'h0);
        waitDrain("read_fast");

        readyDelay = 3;
        rdDelay = 2;
        rdData = 32'hCAFE_F00D;
        applyStimulus(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        waitDrain("read_slow");
        readyDelay = 0;
        rdDelay = 0;

        rdData = 32'h0BAD_C0DE;
        applyStimulus(1'b1, 3'b011, 32'h0000_0050, 32'h1111_1111);
        applyStimulus(1'b0, 3'b010, 32'h0000_0054, 32'h0);
        waitDrain("error_then_read");

        applyStimulus(1'b0, 3'b111, 32'h0000_0058, 32'h0);
        waitDrain("error_size7");

        applyStimulus(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00AB);
        waitDrain("write_byte");

        rdData = 32'hA5A5_A5A5;
        applyStimulus(1'b1, 3'b010, 32'h0000_0004, 32'hA5A5_A5A5);
        applyStimulus(1'b0, 3'b010, 32'h0000_0004, 32'h0);
        waitDrain("back_to_back");

        for (int i = 0; i < 4; i++) begin
            i_hsel = idleSel[i];
            i_htrans = idleTrans[i];
            i_hwrite = 1'b1;
            i_hsize = 3'b010;
            i_haddr = 32'h0000_0100;
            @(negedge clk);
            #2;
            checkOutput("norequest_valid", 32'(o_valid), 32'd0);
            checkOutput("norequest_hreadyout", 32'(o_hreadyout), 32'd1);
            @(negedge clk);
        end
        i_hsel = 1'b0;
        i_htrans = 2'b00;
        repeat (2) @(negedge clk);

        readyDelay = 20;
        applyStimulus(1'b1, 3'b010, 32'h0000_0030, 32'h1111_2222);
        @(negedge clk);
        #3;
        checkOutput("prereset_valid", 32'(o_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkResetOutputs("midreset");
        reqQ.delete();
        rspQ.delete();
        lastRead = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        readyDelay = 0;
        @(negedge clk);

        rdData = 32'h5555_AAAA;
        applyStimulus(1'b1, 3'b010, 32'h0000_0060, 32'h5555_AAAA);
        applyStimulus(1'b0, 3'b010, 32'h0000_0060, 32'h0);
        waitDrain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
